// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//   state_e     : memory-wait FSM states (RUN, WAIT)
//   NOP_INSTR   : instruction word loaded into a flushed pipeline register
//   RESET_PC    : pc value carried by a bubble
//   REG_ZERO    : register $0, which never creates a dependency
//   MD_CNT_W    : width of the mult/div busy counter (holds up to 63)
//   src_hit()   : "this ID source reads the register the EX load writes"
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam int          MD_CNT_W  = 6;

  // A write to $0 is discarded, so it can never feed a later read.
  function automatic logic src_hit(input logic       used,
                                   input logic [4:0] src,
                                   input logic [4:0] dst);
    return used && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Busy timer for the multi-cycle HI/LO unit.
//   clk, rstn : clock, asynchronous active-low reset
//   load      : start pulse; counter takes MD_LAT on the next edge
//   busy      : counter is non-zero
// After a load in cycle t, busy is high for cycles t+1 .. t+MD_LAT.
module md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic busy
);

  logic [MD_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= MD_CNT_W'(MD_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage datapath.
// Inputs : ID sources (id_rs/id_rt + use flags), id_is_md, id_use_hilo,
//          br_flag, EX load info (ex_is_load, ex_rt), dmem_req/dmem_ack.
// Outputs: register enables (pc/if_id/id_ex/ex_mem), bubble loads
//          (if_id/id_ex/mem_wb flush), md_start/md_busy, stall_cnt,
//          plus dbg_state (1 = WAIT) and dbg_err (sticky protocol error).
//
// Data-memory handshake: dmem_req is held by MEM for as long as the access
// is outstanding; the access completes on the cycle dmem_ack is high. The
// ack cycle itself does not stall. A req that drops before any ack is a
// protocol error: the FSM returns to RUN and sets dbg_err until reset.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_md,
  input  logic             id_use_hilo,
  input  logic             br_flag,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rt,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dbg_state,
  output logic             dbg_err
);

  state_e state, state_nxt;
  logic   err_q, err_nxt;
  logic   mem_stall, load_use, hilo_haz;

  // ---------------- hazard detection ----------------
  assign mem_stall = (dmem_req && !dmem_ack) || (state == WAIT && !dmem_ack);
  assign load_use  = ex_is_load &&
                     (src_hit(id_use_rs, id_rs, ex_rt) ||
                      src_hit(id_use_rt, id_rt, ex_rt));
  assign hilo_haz  = md_busy && (id_is_md || id_use_hilo);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    unique case (state)
      RUN: begin
        if (dmem_req && !dmem_ack) state_nxt = WAIT;
      end
      WAIT: begin
        if (dmem_ack) begin
          state_nxt = RUN;
        end else if (!dmem_req) begin
          state_nxt = RUN;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Reset forces a full bubble. A pending branch is ignored under any stall;
  // ID is held, so br_flag comes back once the stall clears.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    md_start     = 1'b0;
    if (!rstn) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (load_use || hilo_haz) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end else begin
      if_id_flush  = br_flag;
      // hilo_haz already covers id_is_md while busy
      md_start     = id_is_md;
    end
  end

  assign dbg_state = (state == WAIT);
  assign dbg_err   = err_q;

  // ---------------- mult/div busy timer ----------------
  md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
    .clk  (clk),
    .rstn (rstn),
    .load (md_start),
    .busy (md_busy)
  );

  // ---------------- stall performance counter ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_use_rs, id_use_rt, id_is_md, id_use_hilo, br_flag, ex_is_load;
  logic dmem_req, dmem_ack;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, md_start, md_busy;
  logic [31:0] stall_cnt;
  logic dbg_state, dbg_err;

  logic pc_en4, if_id_en4, id_ex_en4, ex_mem_en4;
  logic if_id_flush4, id_ex_flush4, mem_wb_flush4, md_start4, md_busy4;
  logic [3:0] stall_cnt4;
  logic dbg_state4, dbg_err4;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_md(id_is_md), .id_use_hilo(id_use_hilo), .br_flag(br_flag),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state), .dbg_err(dbg_err)
  );

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_md(id_is_md), .id_use_hilo(id_use_hilo), .br_flag(br_flag),
    .ex_is_load(ex_is_load), .ex_rt(ex_rt),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .mem_wb_flush(mem_wb_flush4),
    .md_start(md_start4), .md_busy(md_busy4), .stall_cnt(stall_cnt4),
    .dbg_state(dbg_state4), .dbg_err(dbg_err4)
  );

  // Control patterns: {pc_en, if_id_en, id_ex_en, ex_mem_en,
  //                    if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [6:0] P_RUN = 7'b1111_000;
  localparam logic [6:0] P_LU  = 7'b0011_010;
  localparam logic [6:0] P_BR  = 7'b1111_100;
  localparam logic [6:0] P_MEM = 7'b0000_001;
  localparam logic [6:0] P_RST = 7'b0000_111;

  // ---------------- scoreboard ----------------
  // entry: {pattern[6:0], md_start, md_busy, wait, err, cnt32[31:0], cnt4[3:0]}
  localparam int W = 47;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;
  logic [31:0] m32 = '0;
  logic [3:0]  m4  = '0;

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_is_md = 1'b0; id_use_hilo = 1'b0; br_flag = 1'b0;
    ex_is_load = 1'b0; ex_rt = 5'd0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  // Push the hand-computed response for the current cycle; the stall-count
  // model advances when the expected pc_en is 0 outside reset.
  task automatic e(input logic [6:0] pat, input logic st, input logic bz,
                   input logic wt, input logic er);
    if (!rstn) begin
      m32 = '0;
      m4  = '0;
    end
    exp_q.push_back({pat, st, bz, wt, er, m32, m4});
    if (rstn && !pat[6]) begin
      m32 = m32 + 32'd1;
      if (m4 != 4'hf) m4 = m4 + 4'd1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] ex;
    logic [10:0] obs, obs4;
    cyc_no++;
    if (exp_q.size() > 0) begin
      ex   = exp_q.pop_front();
      obs  = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
              mem_wb_flush, md_start, md_busy, dbg_state, dbg_err};
      obs4 = {pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, if_id_flush4, id_ex_flush4,
              mem_wb_flush4, md_start4, md_busy4, dbg_state4, dbg_err4};
      n_checks++;
      if ({obs, stall_cnt} === ex[46:4]) n_pass++;
      else $display("FAIL cyc%0d ctl32 got ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                    cyc_no, obs, stall_cnt, ex[46:36], ex[35:4]);
      n_checks++;
      if ({obs4, stall_cnt4} === {ex[46:36], ex[3:0]}) n_pass++;
      else $display("FAIL cyc%0d ctl4 got ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                    cyc_no, obs4, stall_cnt4, ex[46:36], ex[3:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_in();
    rstn = 1'b0;
    tick(); rstn = 1'b0; e(P_RST, 0, 0, 0, 0);
    tick(); rstn = 1'b0; e(P_RST, 0, 0, 0, 0);
    tick(); rstn = 1'b1; e(P_RUN, 0, 0, 0, 0);

    // load-use on rs: exactly one bubble
    tick(); ex_is_load = 1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1; e(P_LU, 0, 0, 0, 0);
    tick(); e(P_RUN, 0, 0, 0, 0);
    // load to $0 never stalls
    tick(); ex_is_load = 1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1; e(P_RUN, 0, 0, 0, 0);
    // rt path, and a matching but unused source
    tick(); ex_is_load = 1; ex_rt = 5'd9; id_rt = 5'd9; id_use_rt = 1; e(P_LU, 0, 0, 0, 0);
    tick(); ex_is_load = 1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd9; e(P_RUN, 0, 0, 0, 0);

    // branch under load-use: suppressed, then taken next cycle
    tick(); br_flag = 1; ex_is_load = 1; ex_rt = 5'd3; id_rs = 5'd3; id_use_rs = 1;
    e(P_LU, 0, 0, 0, 0);
    tick(); br_flag = 1; id_rs = 5'd3; id_use_rs = 1; e(P_BR, 0, 0, 0, 0);
    tick(); e(P_RUN, 0, 0, 0, 0);

    // div then mflo: 4 held cycles, stall_cnt ends at 4
    tick(); rstn = 1'b0; e(P_RST, 0, 0, 0, 0);
    tick(); rstn = 1'b1; id_is_md = 1; e(P_RUN, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); id_use_hilo = 1; e(P_LU, 0, 1, 0, 0);
    end
    tick(); id_use_hilo = 1; e(P_RUN, 0, 0, 0, 0);
    tick(); e(P_RUN, 0, 0, 0, 0);

    // back-to-back div: second one waits, no second start while busy
    tick(); id_is_md = 1; e(P_RUN, 1, 0, 0, 0);
    tick(); id_is_md = 1; e(P_LU, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); e(P_RUN, 0, 1, 0, 0);
    end
    tick(); e(P_RUN, 0, 0, 0, 0);

    // memory wait of 3 cycles; md counter runs down underneath
    tick(); id_is_md = 1; e(P_RUN, 1, 0, 0, 0);
    tick(); dmem_req = 1; e(P_MEM, 0, 1, 0, 0);
    tick(); dmem_req = 1; e(P_MEM, 0, 1, 1, 0);
    tick(); dmem_req = 1; e(P_MEM, 0, 1, 1, 0);
    tick(); dmem_req = 1; dmem_ack = 1; e(P_RUN, 0, 1, 1, 0);
    tick(); e(P_RUN, 0, 0, 0, 0);

    // div blocked by memory wait, starts on the ack cycle
    tick(); id_is_md = 1; dmem_req = 1; e(P_MEM, 0, 0, 0, 0);
    tick(); id_is_md = 1; dmem_req = 1; dmem_ack = 1; e(P_RUN, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); e(P_RUN, 0, 1, 0, 0);
    end
    tick(); e(P_RUN, 0, 0, 0, 0);

    // req and ack together in RUN: no stall, stays RUN
    tick(); dmem_req = 1; dmem_ack = 1; e(P_RUN, 0, 0, 0, 0);
    tick(); e(P_RUN, 0, 0, 0, 0);

    // req dropped without ack: back to RUN with sticky error
    tick(); dmem_req = 1; e(P_MEM, 0, 0, 0, 0);
    tick(); e(P_MEM, 0, 0, 1, 0);
    tick(); e(P_RUN, 0, 0, 0, 1);
    tick(); e(P_RUN, 0, 0, 0, 1);

    // memory wait outranks load-use; load-use appears on the ack cycle
    tick(); dmem_req = 1; ex_is_load = 1; ex_rt = 5'd5; id_rt = 5'd5; id_use_rt = 1;
    e(P_MEM, 0, 0, 0, 1);
    tick(); dmem_req = 1; dmem_ack = 1; ex_is_load = 1; ex_rt = 5'd5; id_rt = 5'd5;
    id_use_rt = 1; e(P_LU, 0, 0, 1, 1);
    tick(); e(P_RUN, 0, 0, 0, 1);

    // reset while in WAIT with stall_cnt = 5
    tick(); rstn = 1'b0; e(P_RST, 0, 0, 0, 0);
    tick(); rstn = 1'b1; dmem_req = 1; e(P_MEM, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); dmem_req = 1; e(P_MEM, 0, 0, 1, 0);
    end
    tick(); rstn = 1'b0; dmem_req = 1; e(P_RST, 0, 0, 0, 0);
    tick(); rstn = 1'b1; e(P_RUN, 0, 0, 0, 0);

    // 20 stall cycles: 4-bit counter stops at 15, 32-bit reaches 20
    for (int i = 0; i < 20; i++) begin
      tick(); ex_is_load = 1; ex_rt = 5'd31; id_rs = 5'd31; id_use_rs = 1;
      e(P_LU, 0, 0, 0, 0);
    end
    tick(); e(P_RUN, 0, 0, 0, 0);
    tick(); e(P_RUN, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS datapath. Generates enable/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from load-use hazards, taken branches, the multi-cycle HI/LO (mult/div) unit and the data-memory wait handshake. Owns the mult/div busy timer, the memory-wait FSM and a saturating stall-cycle performance counter.

## Interface
- MD_LAT, 32: cycles the mult/div unit stays busy after a start; legal range 2..63.
- CNT_W, 32: width of the stall performance counter.

- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
- id_is_md  in  1  ID holds mult/multu/div/divu.
- id_use_hilo  in  1  ID holds mfhi/mflo/mthi/mtlo.
- br_flag  in  1  branch/jump taken, resolved in ID.
- ex_is_load  in  1  EX holds a load.
- ex_rt  in  5  load destination in EX.
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register update enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (nop, pc 32'h3000).
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- md_busy  out  1  mult/div unit is running.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.

## Operation
- Priority, highest first: MEM_WAIT > load-use > HI/LO hazard > branch flush > run.
- Memory wait (mem_stall = dmem_req & !dmem_ack, or FSM in WAIT & !dmem_ack): all four enables 0, mem_wb_flush=1, other flushes 0.
- Load-use: ex_is_load & ex_rt!=0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)): pc_en=0, if_id_en=0, id_ex_flush=1.
- HI/LO hazard: md_busy & (id_is_md | id_use_hilo): same controls as load-use.
- Branch: br_flag and no higher stall: if_id_flush=1, all enables 1. Under any stall br_flag is ignored; ID is held, so the branch re-asserts when the stall clears.
- md_start = id_is_md & !md_busy & no stall of any kind. The busy counter loads MD_LAT on the next edge. md_busy = (counter != 0). The counter decrements every cycle, including during MEM_WAIT.
- Run: all enables 1, all flushes 0.
- FSM states: RUN, WAIT.
  - RUN -> WAIT when dmem_req & !dmem_ack.
  - WAIT -> RUN when dmem_ack.
  - WAIT -> RUN with sticky err flag (internal, visible in simulation) if dmem_req drops without ack.
- stall_cnt increments on every edge where pc_en=0 while rstn=1. It holds at all-ones.

## Timing
- All outputs except md_busy and stall_cnt are combinational from inputs and state; zero-cycle latency.
- Reset (rstn=0, asynchronous):
  - State RUN, busy counter 0, stall_cnt 0.
  - Forced outputs: all enables 0, all three flushes 1, md_start 0, md_busy 0.
- First edge after reset release evaluates normally.
- Load-use costs exactly 1 bubble. It clears the next cycle because the load has moved to MEM.
- Mult/div:
  - md_start in cycle t; md_busy is high for cycles t+1..t+MD_LAT.
  - A dependent instruction in ID is released in cycle t+MD_LAT+1.
- Memory: a wait of N cycles without ack freezes the pipeline for N cycles. The ack cycle itself has mem_stall=0.
- Simultaneous dmem_req & dmem_ack in RUN: no stall, stays RUN.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum (RUN, WAIT);
  - nop encoding 32'h0;
  - reset PC 32'h3000;
  - register-zero constant.
- One sub-module, md_timer: loadable down-counter with busy output, parameter MD_LAT.
- Everything else stays inside hazard_ctrl.

## Test plan
- Reset mid-stall:
  - Stimulus: assert rstn=0 while in WAIT with stall_cnt=5.
  - Required: immediately flushes=1 and enables=0.
  - After release: state RUN, stall_cnt=0.
- Load-use:
  - Stimulus: ex_is_load=1, ex_rt=8, id_rs=8, id_use_rs=1.
  - Required: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1.
  - Same with ex_rt=0: no stall.
- Branch vs stall:
  - Stimulus: br_flag=1 together with a load-use hazard.
  - Required: no if_id_flush in the stall cycle; if_id_flush=1 in the next cycle.
- Mult/div, MD_LAT=4:
  - Stimulus: div in ID, then mflo in ID.
  - Required: md_start pulses once; md_busy high for 4 cycles; mflo held 4 cycles; stall_cnt=4.
- Memory wait:
  - Stimulus: dmem_req=1 with ack after 3 cycles.
  - Required: 3 cycles with all enables 0 and mem_wb_flush=1; RUN on the ack cycle; the md counter keeps decrementing throughout.
- Saturation:
  - Stimulus: CNT_W=4, hold a stall for 20 cycles.
  - Required: stall_cnt stops at 15.
